// File: rtl/wb_data_mem_slave_if.sv
// Wishbone B4 classic-cycle bus bundle between one master and the data memory slave.
// Latency: none (wiring only).
// Backpressure: the slave stretches a cycle by withholding ack/err; the master holds cyc/stb until then.
interface wb_data_mem_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_data_mem_slave.sv
// Wishbone B4 classic slave wrapping a byte-lane-writable 32-bit word memory at BASE_ADDR.
// Latency: ack/err is sampled WAIT_STATES+1 edges after the accepting edge; accepts are WAIT_STATES+2 apart.
// Backpressure: one transfer at a time; dropping cyc/stb while waiting aborts with no termination.
module wb_data_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  wb_data_mem_slave_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;

  // Request captured on the accepting edge
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdat;
  logic          r_req_err;

  // Registered bus outputs
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdat;

  // Storage; deliberately not reset
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_idle;
  logic          w_accept;
  logic          w_in_range;
  logic          w_req_err;
  logic          w_err_now;
  logic          w_we_now;
  logic [AW-1:0] w_idx_now;

  assign w_req    = bus.wb_cyc_i && bus.wb_stb_i;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && w_req;

  // BASE_ADDR is aligned to the window size, so the window is just a match on the upper bits
  assign w_in_range = (bus.wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_req_err  = !w_in_range || (bus.wb_adr_i[1:0] != 2'b00) ||
                      (bus.wb_we_i && (bus.wb_sel_i == 4'b0000));

  // With zero wait states RESP is entered on the accepting edge, so decode from the live bus there
  assign w_err_now = w_idle ? w_req_err : r_req_err;
  assign w_we_now  = w_idle ? bus.wb_we_i : r_we;
  assign w_idx_now = w_idle ? bus.wb_adr_i[AW+1:2] : r_idx;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, wait counter and request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_sel     <= 4'b0000;
      r_wdat    <= 32'h0;
      r_req_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt     <= WS_LOAD;
        r_idx     <= bus.wb_adr_i[AW+1:2];
        r_we      <= bus.wb_we_i;
        r_sel     <= bus.wb_sel_i;
        r_wdat    <= bus.wb_dat_i;
        r_req_err <= w_req_err;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Termination strobe and read data, raised for the single RESP cycle only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= 32'h0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= 32'h0;
      if (w_state_nxt == ST_RESP) begin
        if (w_err_now) begin
          r_err <= 1'b1;
        end else begin
          r_ack <= 1'b1;
          if (!w_we_now) begin
            r_rdat <= r_mem[w_idx_now];
          end
        end
      end
    end
  end

  // Commit write lanes on the edge that ends an acked RESP; a reset in RESP clears r_ack first
  always_ff @(posedge clk) begin
    if (r_ack && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdat[8*b +: 8];
        end
      end
    end
  end

  assign bus.wb_ack_o = r_ack;
  assign bus.wb_err_o = r_err;
  assign bus.wb_dat_o = r_rdat;

endmodule

// File: tb/tb_wb_data_mem_slave.sv
// Bench: three slaves (1, 3 and 0 wait states, distinct base addresses) sharing one master drive.
// Latency: each transfer is timed from its accepting edge against WAIT_STATES+1.
// Backpressure: master holds cyc/stb until a termination is seen, or drops it to abort.
module tb_wb_data_mem_slave;

  localparam int          DEPTH = 256;
  localparam int          WS0   = 1;
  localparam int          WS1   = 3;
  localparam int          WS2   = 0;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_2000;
  localparam logic [31:0] BASE2 = 32'h8000_0400;

  logic        clk;
  logic        reset;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  int          sel_dut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl_mem [3][DEPTH];
  logic [3:0]  mdl_kn  [3][DEPTH];

  wb_data_mem_slave_if bus0 ();
  wb_data_mem_slave_if bus1 ();
  wb_data_mem_slave_if bus2 ();

  wb_data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0), .BASE_ADDR(BASE0))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  wb_data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1), .BASE_ADDR(BASE1))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  wb_data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS2), .BASE_ADDR(BASE2))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Only the selected slave sees cyc; the others see stb without cyc, which must be ignored
  assign bus0.wb_cyc_i = m_cyc && (sel_dut == 0);
  assign bus1.wb_cyc_i = m_cyc && (sel_dut == 1);
  assign bus2.wb_cyc_i = m_cyc && (sel_dut == 2);
  assign bus0.wb_stb_i = m_stb;
  assign bus1.wb_stb_i = m_stb;
  assign bus2.wb_stb_i = m_stb;
  assign bus0.wb_we_i  = m_we;
  assign bus1.wb_we_i  = m_we;
  assign bus2.wb_we_i  = m_we;
  assign bus0.wb_adr_i = m_adr;
  assign bus1.wb_adr_i = m_adr;
  assign bus2.wb_adr_i = m_adr;
  assign bus0.wb_sel_i = m_sel;
  assign bus1.wb_sel_i = m_sel;
  assign bus2.wb_sel_i = m_sel;
  assign bus0.wb_dat_i = m_dat;
  assign bus1.wb_dat_i = m_dat;
  assign bus2.wb_dat_i = m_dat;

  logic        o_ack, o_err, o_oth;
  logic [31:0] o_dat;

  // Response of the selected slave, plus any activity on the unselected ones
  always_comb begin
    o_ack = 1'b0;
    o_err = 1'b0;
    o_dat = 32'h0;
    o_oth = 1'b0;
    case (sel_dut)
      0: begin
        o_ack = bus0.wb_ack_o; o_err = bus0.wb_err_o; o_dat = bus0.wb_dat_o;
        o_oth = bus1.wb_ack_o | bus1.wb_err_o | bus2.wb_ack_o | bus2.wb_err_o;
      end
      1: begin
        o_ack = bus1.wb_ack_o; o_err = bus1.wb_err_o; o_dat = bus1.wb_dat_o;
        o_oth = bus0.wb_ack_o | bus0.wb_err_o | bus2.wb_ack_o | bus2.wb_err_o;
      end
      default: begin
        o_ack = bus2.wb_ack_o; o_err = bus2.wb_err_o; o_dat = bus2.wb_dat_o;
        o_oth = bus0.wb_ack_o | bus0.wb_err_o | bus1.wb_ack_o | bus1.wb_err_o;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] base_of(input int d);
    case (d)
      0:       return BASE0;
      1:       return BASE1;
      default: return BASE2;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    case (d)
      0:       return WS0;
      1:       return WS1;
      default: return WS2;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one completed transfer: decode window, alignment, empty write mask
  task automatic model_xfer(input int d, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat,
                            output logic e_err, output logic [31:0] e_dat, output logic [31:0] e_msk);
    logic [63:0] lo, hi, a;
    logic [31:0] off;
    int          idx;
    lo    = {32'h0, base_of(d)};
    hi    = lo + 64'(4 * DEPTH);
    a     = {32'h0, adr};
    e_err = (a < lo) || (a >= hi) || (adr[1:0] != 2'b00) || (we && (sel == 4'h0));
    e_dat = 32'h0;
    e_msk = 32'h0;
    if (!e_err) begin
      off = adr - base_of(d);
      idx = int'(off >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) begin
            mdl_mem[d][idx][8*b +: 8] = dat[8*b +: 8];
            mdl_kn[d][idx][b]         = 1'b1;
          end
        end
      end else begin
        e_dat = mdl_mem[d][idx];
        for (int b = 0; b < 4; b++) begin
          if (mdl_kn[d][idx][b]) e_msk[8*b +: 8] = 8'hFF;
        end
      end
    end
  endtask

  // One complete classic cycle on slave d, checked against the reference model
  task automatic xfer(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input string tag, output logic [31:0] rd);
    logic        e_err, seen, s_ack, s_err, s_oth;
    logic [31:0] e_dat, e_msk, s_dat, m;
    int          lat;
    @(negedge clk);
    sel_dut = d; m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_sel = sel; m_dat = dat;
    @(posedge clk);
    seen = 1'b0; lat = 0; s_ack = 1'b0; s_err = 1'b0; s_oth = 1'b0; s_dat = 32'h0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (o_ack || o_err) begin
        seen = 1'b1; lat = i; s_ack = o_ack; s_err = o_err; s_dat = o_dat; s_oth = o_oth;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    model_xfer(d, we, adr, sel, dat, e_err, e_dat, e_msk);
    m = (e_err || we) ? 32'hFFFF_FFFF : e_msk;
    chk_eq({tag, " seen"}, 32'(seen), 32'd1);
    chk_eq({tag, " latency"}, lat, ws_of(d) + 1);
    chk_eq({tag, " ack"}, 32'(s_ack), 32'(!e_err));
    chk_eq({tag, " err"}, 32'(s_err), 32'(e_err));
    chk_eq({tag, " dat"}, s_dat & m, (e_err || we) ? 32'h0 : (e_dat & m));
    chk_eq({tag, " others quiet"}, 32'(s_oth), 32'd0);
    rd = s_dat;
    @(negedge clk);
    chk_eq({tag, " one-shot"}, {29'd0, o_ack, o_err, o_oth}, 32'd0);
    chk_eq({tag, " dat idle"}, o_dat, 32'h0);
  endtask

  logic [31:0] rd;
  logic [31:0] sd [4];
  int          hits, k, d, kind;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < DEPTH; j++) mdl_kn[i][j] = 4'h0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = 0; m_sel = 0; m_dat = 0; sel_dut = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset outs 0", {bus0.wb_ack_o, bus0.wb_err_o} | bus0.wb_dat_o, 32'h0);
    chk_eq("reset outs 1", {bus1.wb_ack_o, bus1.wb_err_o} | bus1.wb_dat_o, 32'h0);
    chk_eq("reset outs 2", {bus2.wb_ack_o, bus2.wb_err_o} | bus2.wb_dat_o, 32'h0);
    reset = 1'b1;

    // Write then read, one wait state; reads ignore sel
    xfer(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, "wr 0x10", rd);
    xfer(0, 0, 32'h10, 4'h0, 32'h0, "rd 0x10", rd);
    chk_eq("rd 0x10 value", rd, 32'hDEAD_BEEF);

    // Byte-lane merge
    xfer(0, 1, 32'h14, 4'hF, 32'h1122_3344, "wr 0x14", rd);
    xfer(0, 1, 32'h14, 4'h5, 32'hAABB_CCDD, "wr 0x14 lanes", rd);
    xfer(0, 0, 32'h14, 4'h1, 32'h0, "rd 0x14", rd);
    chk_eq("lane merge", rd, 32'h11BB_33DD);

    // Error terminations leave memory alone, including no aliasing past the window
    xfer(0, 0, 32'h2, 4'hF, 32'h0, "rd unaligned", rd);
    xfer(0, 1, 32'h0, 4'hF, 32'h0102_0304, "wr word0", rd);
    xfer(0, 1, BASE0 + 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF, "wr past end", rd);
    xfer(0, 0, 32'h0, 4'hF, 32'h0, "rd word0", rd);
    chk_eq("no alias write", rd, 32'h0102_0304);
    xfer(0, 1, 32'h10, 4'h0, 32'h0, "wr empty sel", rd);
    xfer(0, 0, 32'h10, 4'hF, 32'h0, "rd after empty sel", rd);
    chk_eq("empty sel no write", rd, 32'hDEAD_BEEF);
    xfer(0, 1, BASE0 + 32'(4 * DEPTH - 4), 4'hF, 32'h5A5A_0001, "wr last word", rd);
    xfer(0, 0, BASE0 + 32'(4 * DEPTH - 4), 4'hF, 32'h0, "rd last word", rd);
    xfer(1, 0, BASE1 - 32'd4, 4'hF, 32'h0, "rd below base", rd);

    // Abort while waiting (three wait states)
    xfer(1, 1, BASE1 + 32'h8, 4'hF, 32'hCAFE_0001, "wr pre-abort", rd);
    @(negedge clk);
    sel_dut = 1; m_cyc = 1; m_stb = 1; m_we = 1; m_adr = BASE1 + 32'h8; m_sel = 4'hF; m_dat = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    m_cyc = 0; m_stb = 0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_ack || o_err) hits++;
    end
    chk_eq("abort no termination", hits, 0);
    xfer(1, 0, BASE1 + 32'h8, 4'hF, 32'h0, "rd post-abort", rd);
    chk_eq("abort no write", rd, 32'hCAFE_0001);

    // Reset while waiting
    xfer(1, 1, BASE1 + 32'hC, 4'hF, 32'h0A0B_0C0D, "wr pre-reset", rd);
    @(negedge clk);
    sel_dut = 1; m_cyc = 1; m_stb = 1; m_we = 1; m_adr = BASE1 + 32'hC; m_sel = 4'hF; m_dat = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_eq("reset in wait outs", {o_ack, o_err} | o_dat, 32'h0);
    m_cyc = 0; m_stb = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    xfer(1, 0, BASE1 + 32'hC, 4'hF, 32'h0, "rd post-reset", rd);
    chk_eq("reset in wait no write", rd, 32'h0A0B_0C0D);
    xfer(1, 1, BASE1 + 32'hC, 4'hF, 32'h55AA_55AA, "wr after reset", rd);
    xfer(1, 0, BASE1 + 32'hC, 4'hF, 32'h0, "rd after reset", rd);
    chk_eq("write after reset", rd, 32'h55AA_55AA);

    // Reset during the acknowledge cycle clears ack at once and suppresses the write
    xfer(0, 1, 32'h18, 4'hF, 32'h7777_7777, "wr 0x18", rd);
    @(negedge clk);
    sel_dut = 0; m_cyc = 1; m_stb = 1; m_we = 1; m_adr = 32'h18; m_sel = 4'hF; m_dat = 32'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_eq("resp ack before reset", 32'(o_ack), 32'd1);
    #1 reset = 1'b0;
    #1 chk_eq("reset in resp ack", 32'(o_ack), 32'd0);
    m_cyc = 0; m_stb = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    xfer(0, 0, 32'h18, 4'hF, 32'h0, "rd 0x18", rd);
    chk_eq("reset in resp no write", rd, 32'h7777_7777);

    // Zero wait states, strobe held: ack on alternate cycles
    for (int i = 0; i < 4; i++) begin
      sd[i] = $urandom;
      xfer(2, 1, BASE2 + 32'h40 + 32'(4 * i), 4'hF, sd[i], "wr stream", rd);
    end
    @(negedge clk);
    sel_dut = 2; m_cyc = 1; m_stb = 1; m_we = 0; m_sel = 4'hF; m_adr = BASE2 + 32'h40;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk_eq("stream ack", 32'(o_ack), 32'(c % 2));
      if (o_ack && k < 4) begin
        chk_eq("stream dat", o_dat, sd[k]);
        k++;
        m_adr = BASE2 + 32'h40 + 32'(4 * k);
      end else begin
        chk_eq("stream dat idle", o_dat, 32'h0);
      end
    end
    m_cyc = 0; m_stb = 0;
    @(negedge clk);

    // Randomized traffic against the reference model
    for (int dd = 0; dd < 3; dd++)
      for (int w = 0; w < 16; w++)
        xfer(dd, 1, base_of(dd) + 32'(4 * w), 4'hF, $urandom, "rnd init", rd);
    for (int n = 0; n < 150; n++) begin
      d    = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      case (kind)
        6:       a = base_of(d) + 32'(4 * (DEPTH - 1));
        7:       a = base_of(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        8:       a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        9:       a = base_of(d) - 32'd4;
        default: a = base_of(d) + 32'(4 * $urandom_range(0, 15));
      endcase
      xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, "rnd", rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
